// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the MMCM clock-source selection controller.
package clk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD_RST  = 3'd0,
    ST_SWITCH    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  typedef enum logic {
    SRC_DAC  = 1'b0,
    SRC_PCIE = 1'b1
  } src_t;

  // Consecutive synchronized-lock cycles needed to declare lock / loss of lock.
  localparam int LOCK_HI_CYCLES = 8;
  localparam int LOCK_LO_CYCLES = 2;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/clk_src_sel_ctrl_if.sv
// Request/status bundle between the controller and its host.
interface clk_src_sel_ctrl_if;
  logic       req_valid;
  logic       req_src;
  logic       req_err;
  logic       busy;
  logic       run_ok;
  logic       fault;
  logic [1:0] retry_cnt;

  modport master (output req_valid, req_src,
                  input  req_err, busy, run_ok, fault, retry_cnt);
  modport slave  (input  req_valid, req_src,
                  output req_err, busy, run_ok, fault, retry_cnt);
endinterface

// File: rtl/clk_activity_det.sv
// Detects whether pcie_clk is running, judged over fixed dac_clk windows.
module clk_activity_det #(
  parameter int ACT_WINDOW = 64
) (
  input  logic dac_clk,
  input  logic reset,
  input  logic pcie_clk,
  output logic pcie_active
);
  localparam int WIN_W = (ACT_WINDOW > 1) ? $clog2(ACT_WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ACT_WINDOW - 1);

  logic             tgl;
  logic [2:0]       tgl_sync;
  logic [WIN_W-1:0] win_cnt;
  logic [1:0]       edge_cnt;
  logic             edge_seen;

  // Divide pcie_clk into a slow toggle that can be sampled safely.
  always_ff @(posedge pcie_clk or posedge reset) begin
    if (reset) tgl <= 1'b0;
    else       tgl <= ~tgl;
  end

  // Bring the toggle into dac_clk; the third flop is the edge-detect history.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) tgl_sync <= '0;
    else       tgl_sync <= {tgl_sync[1:0], tgl};
  end

  assign edge_seen = tgl_sync[2] ^ tgl_sync[1];

  // Count edges per window (saturating at 2) and publish the verdict at each boundary.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      pcie_active <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      pcie_active <= (edge_cnt + 2'(edge_seen)) >= 2'd2;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (edge_seen && edge_cnt != 2'd2) edge_cnt <= edge_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/clk_src_sel_ctrl.sv
// MMCM input-source sequencer: reset/switch/lock acquisition with retry,
// PCIe->DAC fallback, and a host request port.
module clk_src_sel_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int MAX_RETRY    = 3,
  parameter int ACT_WINDOW   = 64
) (
  input  logic dac_clk,
  input  logic reset,
  input  logic pcie_clk,
  input  logic mmcm_locked,
  output logic clk_sel,
  output logic mmcm_reset,
  output logic pcie_active,
  clk_src_sel_ctrl_if.slave ctl
);
  // mmcm_reset spans HOLD_RST + SWITCH + RELEASE, totalling RST_CYCLES.
  localparam int HOLD_CYC = (RST_CYCLES / 2 > 0) ? RST_CYCLES / 2 : 1;
  localparam int REL_CYC  = (RST_CYCLES - HOLD_CYC - 1 > 0) ? RST_CYCLES - HOLD_CYC - 1 : 1;
  localparam int CNT_TOP  = (LOCK_TIMEOUT > HOLD_CYC + REL_CYC) ? LOCK_TIMEOUT : HOLD_CYC + REL_CYC;
  localparam int CNT_W    = $clog2(CNT_TOP + 1);
  localparam int DEB_W    = $clog2(LOCK_HI_CYCLES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_TOP);
  localparam logic [DEB_W-1:0] HI_LAST   = DEB_W'(LOCK_HI_CYCLES - 1);
  localparam logic [DEB_W-1:0] LO_LAST   = DEB_W'(LOCK_LO_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_SAT   = DEB_W'(LOCK_HI_CYCLES);

  state_t           state, state_n;
  src_t             target, target_n;
  logic [1:0]       retry_cnt, retry_n;
  logic             req_err, req_err_n;
  logic [CNT_W-1:0] cnt;
  logic [DEB_W-1:0] deb;
  logic [1:0]       lock_sync;
  logic             lock_s;
  logic             act_q;
  logic             act_fall;

  clk_activity_det #(.ACT_WINDOW(ACT_WINDOW)) u_act (
    .dac_clk     (dac_clk),
    .reset       (reset),
    .pcie_clk    (pcie_clk),
    .pcie_active (pcie_active)
  );

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) lock_sync <= '0;
    else       lock_sync <= {lock_sync[0], mmcm_locked};
  end

  assign lock_s   = lock_sync[1];
  assign act_fall = act_q & ~pcie_active;

  // Next-state, target and retry decisions; host requests are resolved last.
  always_comb begin
    state_n   = state;
    target_n  = target;
    retry_n   = retry_cnt;
    req_err_n = 1'b0;
    unique case (state)
      ST_HOLD_RST: if (cnt == HOLD_LAST) state_n = ST_SWITCH;
      ST_SWITCH:   state_n = ST_RELEASE;
      ST_RELEASE:  if (cnt == REL_LAST) state_n = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (act_fall && target == SRC_PCIE) begin
          target_n = SRC_DAC;
          retry_n  = '0;
          state_n  = ST_HOLD_RST;
        end else if (lock_s && deb == HI_LAST) begin
          retry_n = '0;
          state_n = ST_RUN;
        end else if (cnt == TO_LAST) begin
          if (int'(retry_cnt) + 1 < MAX_RETRY) begin
            retry_n = sat_inc2(retry_cnt);
            state_n = ST_HOLD_RST;
          end else if (target == SRC_PCIE) begin
            target_n = SRC_DAC;
            retry_n  = '0;
            state_n  = ST_HOLD_RST;
          end else begin
            retry_n = sat_inc2(retry_cnt);
            state_n = ST_FAULT;
          end
        end
      end
      ST_RUN: begin
        if (act_fall && target == SRC_PCIE) begin
          target_n = SRC_DAC;
          retry_n  = '0;
          state_n  = ST_HOLD_RST;
        end else if (!lock_s && deb == LO_LAST) begin
          retry_n = '0;
          state_n = ST_HOLD_RST;
        end
      end
      ST_FAULT: ;
      default:  state_n = ST_HOLD_RST;
    endcase

    if (ctl.req_valid) begin
      if ((state != ST_RUN && state != ST_FAULT) || (ctl.req_src && !pcie_active)) begin
        req_err_n = 1'b1;
      end else if (state == ST_RUN && act_fall && target == SRC_PCIE) begin
        // Forced fallback already in progress this cycle; the request is dropped.
      end else if (!(state == ST_RUN && src_t'(ctl.req_src) == target)) begin
        target_n = src_t'(ctl.req_src);
        retry_n  = '0;
        state_n  = ST_HOLD_RST;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_HOLD_RST;
      target    <= SRC_DAC;
      retry_cnt <= '0;
      req_err   <= 1'b0;
      act_q     <= 1'b0;
      clk_sel   <= 1'b0;
      cnt       <= '0;
      deb       <= '0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      retry_cnt <= retry_n;
      req_err   <= req_err_n;
      act_q     <= pcie_active;
      if (state == ST_SWITCH) clk_sel <= target;
      if (state_n != state)    cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      if (state_n != state) deb <= '0;
      else if ((state == ST_WAIT_LOCK && lock_s) || (state == ST_RUN && !lock_s))
        deb <= (deb == DEB_SAT) ? deb : deb + 1'b1;
      else deb <= '0;
    end
  end

  assign mmcm_reset    = !(state == ST_WAIT_LOCK || state == ST_RUN);
  assign ctl.busy      = !(state == ST_RUN || state == ST_FAULT);
  assign ctl.run_ok    = (state == ST_RUN);
  assign ctl.fault     = (state == ST_FAULT);
  assign ctl.req_err   = req_err;
  assign ctl.retry_cnt = retry_cnt;
endmodule

// File: tb/tb_clk_src_sel_ctrl.sv
// Directed bench for clk_src_sel_ctrl with small timing parameters.
module tb_clk_src_sel_ctrl;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int MAX_RETRY    = 2;
  localparam int ACT_WINDOW   = 16;

  logic dac_clk = 1'b0;
  logic reset = 1'b1;
  logic pcie_clk = 1'b0;
  logic pcie_en = 1'b0;
  logic mmcm_locked = 1'b0;
  logic clk_sel, mmcm_reset, pcie_active;
  int   checks = 0;
  int   errors = 0;

  clk_src_sel_ctrl_if ctl_if();

  clk_src_sel_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .ACT_WINDOW(ACT_WINDOW)
  ) dut (
    .dac_clk     (dac_clk),
    .reset       (reset),
    .pcie_clk    (pcie_clk),
    .mmcm_locked (mmcm_locked),
    .clk_sel     (clk_sel),
    .mmcm_reset  (mmcm_reset),
    .pcie_active (pcie_active),
    .ctl         (ctl_if)
  );

  always #5 dac_clk = ~dac_clk;
  always begin
    #8;
    if (pcie_en) pcie_clk = ~pcie_clk;
  end

  task automatic tick();
    @(negedge dac_clk);
  endtask

  task automatic send_req(input logic src);
    ctl_if.req_valid = 1'b1;
    ctl_if.req_src   = src;
    @(negedge dac_clk);
    ctl_if.req_valid = 1'b0;
  endtask

  task automatic wait_run(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ctl_if.run_ok === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int first_low, first_run;
    logic [8:0] obs;
    ctl_if.req_valid = 1'b0;
    ctl_if.req_src   = 1'b0;
    repeat (3) tick();
    obs = {clk_sel, mmcm_reset, ctl_if.busy, ctl_if.run_ok, ctl_if.fault,
           ctl_if.req_err, ctl_if.retry_cnt, pcie_active};
    checks++;
    if (obs !== 9'b0_1_1_0_0_0_00_0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 9'b0_1_1_0_0_0_00_0);
    end
    reset = 1'b0;
    first_low = -1;
    first_run = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (mmcm_reset === 1'b0 && first_low < 0) first_low = k;
      if (ctl_if.run_ok === 1'b1 && first_run < 0) first_run = k;
      if (k == 10) mmcm_locked = 1'b1;
    end
    checks++;
    if (first_low !== 4) begin
      errors++;
      $display("FAIL reset_mmcm_release: got cycle %0d expected 4", first_low);
    end
    checks++;
    if (first_run !== 20) begin
      errors++;
      $display("FAIL reset_run_ok: got cycle %0d expected 20", first_run);
    end
    checks++;
    if (clk_sel !== 1'b0 || ctl_if.retry_cnt !== 2'd0 || pcie_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_run_state: clk_sel=%b retry=%0d act=%b expected 0 0 0",
               clk_sel, ctl_if.retry_cnt, pcie_active);
    end
  endtask

  task automatic test_switch_to_pcie();
    int bad, n;
    logic prev;
    pcie_en = 1'b1;
    repeat (40) tick();
    checks++;
    if (pcie_active !== 1'b1) begin
      errors++;
      $display("FAIL pcie_active_rise: got %b expected 1", pcie_active);
    end
    send_req(1'b1);
    checks++;
    if (ctl_if.req_err !== 1'b0 || mmcm_reset !== 1'b1 || ctl_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL pcie_req_accept: req_err=%b mmcm_reset=%b busy=%b expected 0 1 1",
               ctl_if.req_err, mmcm_reset, ctl_if.busy);
    end
    bad = 0;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      prev = clk_sel;
      tick();
      if (clk_sel !== prev && mmcm_reset !== 1'b1) bad++;
      if (ctl_if.run_ok === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL pcie_sel_under_reset: %0d clk_sel changes with mmcm_reset low, expected 0", bad);
    end
    checks++;
    if (n < 0 || clk_sel !== 1'b1 || ctl_if.retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL pcie_run: cycles=%0d clk_sel=%b retry=%0d expected run, 1, 0",
               n, clk_sel, ctl_if.retry_cnt);
    end
    send_req(1'b1);
    checks++;
    if (ctl_if.req_err !== 1'b0 || ctl_if.run_ok !== 1'b1) begin
      errors++;
      $display("FAIL same_src_noop: req_err=%b run_ok=%b expected 0 1",
               ctl_if.req_err, ctl_if.run_ok);
    end
    tick();
    checks++;
    if (ctl_if.run_ok !== 1'b1 || mmcm_reset !== 1'b0 || clk_sel !== 1'b1) begin
      errors++;
      $display("FAIL same_src_hold: run_ok=%b mmcm_reset=%b clk_sel=%b expected 1 0 1",
               ctl_if.run_ok, mmcm_reset, clk_sel);
    end
  endtask

  task automatic test_pcie_fallback();
    int rises, low_len, max_retry, n;
    int lens[4];
    logic prev_mr, found;
    for (int i = 0; i < 4; i++) lens[i] = -1;
    mmcm_locked = 1'b0;
    rises = 0;
    low_len = 0;
    max_retry = 0;
    found = 1'b0;
    prev_mr = mmcm_reset;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (mmcm_reset === 1'b0) low_len++;
      if (mmcm_reset === 1'b1 && prev_mr === 1'b0) begin
        if (rises < 4) lens[rises] = low_len;
        rises++;
        low_len = 0;
      end
      prev_mr = mmcm_reset;
      if (int'(ctl_if.retry_cnt) > max_retry) max_retry = int'(ctl_if.retry_cnt);
      if (clk_sel === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1 || rises !== 3) begin
      errors++;
      $display("FAIL fallback_attempts: found=%b reset_rises=%0d expected 1 3", found, rises);
    end
    checks++;
    if (lens[1] !== LOCK_TIMEOUT || lens[2] !== LOCK_TIMEOUT) begin
      errors++;
      $display("FAIL fallback_timeouts: got %0d,%0d expected %0d,%0d",
               lens[1], lens[2], LOCK_TIMEOUT, LOCK_TIMEOUT);
    end
    checks++;
    if (max_retry !== 1) begin
      errors++;
      $display("FAIL fallback_retry_max: got %0d expected 1", max_retry);
    end
    mmcm_locked = 1'b1;
    wait_run(60, n);
    checks++;
    if (n < 0 || clk_sel !== 1'b0 || ctl_if.retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL fallback_run_dac: cycles=%0d clk_sel=%b retry=%0d expected run, 0, 0",
               n, clk_sel, ctl_if.retry_cnt);
    end
  endtask

  task automatic test_dac_fault();
    int n;
    logic [5:0] obs;
    mmcm_locked = 1'b0;
    n = -1;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (ctl_if.fault === 1'b1) begin
        n = i;
        break;
      end
    end
    obs = {ctl_if.fault, mmcm_reset, ctl_if.busy, ctl_if.run_ok, clk_sel, 1'b0};
    checks++;
    if (n < 0 || obs !== 6'b1_1_0_0_0_0) begin
      errors++;
      $display("FAIL dac_fault_entry: cycles=%0d fault,mr,busy,run,sel=%b expected 11000", n, obs[5:1]);
    end
    checks++;
    if (ctl_if.retry_cnt !== 2'd2) begin
      errors++;
      $display("FAIL dac_fault_retry: got %0d expected 2", ctl_if.retry_cnt);
    end
    repeat (10) tick();
    checks++;
    if (ctl_if.fault !== 1'b1 || mmcm_reset !== 1'b1) begin
      errors++;
      $display("FAIL dac_fault_sticky: fault=%b mmcm_reset=%b expected 1 1", ctl_if.fault, mmcm_reset);
    end
    mmcm_locked = 1'b1;
    send_req(1'b0);
    checks++;
    if (ctl_if.fault !== 1'b0 || ctl_if.busy !== 1'b1 || ctl_if.req_err !== 1'b0 ||
        ctl_if.retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL fault_exit: fault=%b busy=%b req_err=%b retry=%0d expected 0 1 0 0",
               ctl_if.fault, ctl_if.busy, ctl_if.req_err, ctl_if.retry_cnt);
    end
    wait_run(60, n);
    checks++;
    if (n < 0 || clk_sel !== 1'b0) begin
      errors++;
      $display("FAIL fault_reacquire: cycles=%0d clk_sel=%b expected run, 0", n, clk_sel);
    end
  endtask

  task automatic test_activity_loss();
    int n;
    send_req(1'b1);
    wait_run(60, n);
    checks++;
    if (n < 0 || clk_sel !== 1'b1) begin
      errors++;
      $display("FAIL loss_setup_run: cycles=%0d clk_sel=%b expected run, 1", n, clk_sel);
    end
    pcie_en = 1'b0;
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (pcie_active === 1'b0) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n < 0 || n > 2 * ACT_WINDOW + 3) begin
      errors++;
      $display("FAIL loss_detect: got %0d cycles expected 1..%0d", n, 2 * ACT_WINDOW + 3);
    end
    tick();
    checks++;
    if (ctl_if.busy !== 1'b1 || mmcm_reset !== 1'b1 || ctl_if.run_ok !== 1'b0) begin
      errors++;
      $display("FAIL loss_fallback: busy=%b mmcm_reset=%b run_ok=%b expected 1 1 0",
               ctl_if.busy, mmcm_reset, ctl_if.run_ok);
    end
    send_req(1'b0);
    checks++;
    if (ctl_if.req_err !== 1'b1 || ctl_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_req_err: req_err=%b busy=%b expected 1 1", ctl_if.req_err, ctl_if.busy);
    end
    tick();
    checks++;
    if (ctl_if.req_err !== 1'b0) begin
      errors++;
      $display("FAIL busy_req_err_width: got %b expected 0", ctl_if.req_err);
    end
    wait_run(60, n);
    checks++;
    if (n < 0 || clk_sel !== 1'b0) begin
      errors++;
      $display("FAIL loss_run_dac: cycles=%0d clk_sel=%b expected run, 0", n, clk_sel);
    end
    send_req(1'b1);
    checks++;
    if (ctl_if.req_err !== 1'b1 || ctl_if.run_ok !== 1'b1 || clk_sel !== 1'b0) begin
      errors++;
      $display("FAIL inactive_pcie_req: req_err=%b run_ok=%b clk_sel=%b expected 1 1 0",
               ctl_if.req_err, ctl_if.run_ok, clk_sel);
    end
  endtask

  task automatic test_reset_in_wait_lock();
    int n;
    logic found, sel_seen;
    logic [8:0] obs;
    pcie_en = 1'b1;
    repeat (40) tick();
    send_req(1'b1);
    wait_run(60, n);
    checks++;
    if (n < 0 || clk_sel !== 1'b1) begin
      errors++;
      $display("FAIL wl_setup_run: cycles=%0d clk_sel=%b expected run, 1", n, clk_sel);
    end
    mmcm_locked = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ctl_if.retry_cnt === 2'd1 && mmcm_reset === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL wl_reach: got %b expected 1", found);
    end
    #2 reset = 1'b1;
    #1;
    obs = {clk_sel, mmcm_reset, ctl_if.busy, ctl_if.run_ok, ctl_if.fault,
           ctl_if.req_err, ctl_if.retry_cnt, pcie_active};
    checks++;
    if (obs !== 9'b0_1_1_0_0_0_00_0) begin
      errors++;
      $display("FAIL wl_async_reset: got %b expected %b", obs, 9'b0_1_1_0_0_0_00_0);
    end
    tick();
    reset = 1'b0;
    mmcm_locked = 1'b1;
    sel_seen = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (clk_sel !== 1'b0) sel_seen = 1'b1;
      if (ctl_if.run_ok === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n < 0 || sel_seen !== 1'b0) begin
      errors++;
      $display("FAIL wl_restart_dac: cycles=%0d pcie_selected=%b expected run, 0", n, sel_seen);
    end
  endtask

  initial begin
    ctl_if.req_valid = 1'b0;
    ctl_if.req_src   = 1'b0;
    test_reset();
    test_switch_to_pcie();
    test_pcie_fallback();
    test_dac_fault();
    test_activity_loss();
    test_reset_in_wait_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
